// File: rtl/bmp_writer_if.sv
// Purpose : groups the framebuffer read port and the outgoing byte stream of bmp_writer.
// Latency : none, wiring only. fb_rdata is expected one cycle after fb_rd.
// Backpressure: out_ready from the sink stalls out_data/out_last/out_valid, which hold while stalled.
//
// Signals:
//   fb_addr/fb_rd  -> framebuffer   pixel index y*IMG_W + x and read strobe
//   fb_rdata       <- framebuffer   RGB565 pixel, valid the cycle after fb_rd
//   out_data/out_valid/out_last -> sink   byte stream, last flags final byte of file
//   out_ready      <- sink          byte accepted when out_valid && out_ready
interface bmp_writer_if;
  logic [20:0] fb_addr;
  logic        fb_rd;
  logic [15:0] fb_rdata;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  // Writer side.
  modport master (
    output fb_addr, fb_rd, out_data, out_valid, out_last,
    input  fb_rdata, out_ready
  );

  // Framebuffer + sink side.
  modport slave (
    input  fb_addr, fb_rd, out_data, out_valid, out_last,
    output fb_rdata, out_ready
  );
endinterface

// File: rtl/bmp_writer.sv
// Purpose : streams the framebuffer as a 24-bit BMP file (54-byte header, bottom-up BGR888 rows, 4-byte padding).
// Latency : first header byte valid the cycle after start; each pixel adds FETCH+WAIT bubbles before its 3 bytes.
// Backpressure: a byte is held (data/last stable) until out_ready; the FSM only advances on a handshake.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start        begins a file from idle or done; ignored while busy
//   busy, done   file in progress / file complete (cleared by the next start)
//   bus          bmp_writer_if.master: framebuffer read port + byte stream
module bmp_writer #(
  parameter int IMG_W = 1280,
  parameter int IMG_H = 720
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  bmp_writer_if.master  bus
);

  // Geometry of the file.
  localparam int ROW_B   = IMG_W * 3;
  localparam int PAD_B   = (4 - (ROW_B % 4)) % 4;
  localparam int PROW_B  = ROW_B + PAD_B;
  localparam int IMG_SZ  = PROW_B * IMG_H;
  localparam int FILE_SZ = 54 + IMG_SZ;

  localparam logic [31:0] FILE_SZ_W = 32'(FILE_SZ);
  localparam logic [31:0] IMG_SZ_W  = 32'(IMG_SZ);
  localparam logic [31:0] IMG_W_W   = 32'(IMG_W);
  localparam logic [31:0] IMG_H_W   = 32'(IMG_H);

  localparam logic [20:0] ROW_STEP      = 21'(IMG_W);
  localparam logic [20:0] LAST_ROW_BASE = 21'((IMG_H - 1) * IMG_W);
  localparam logic [11:0] X_LAST        = 12'(IMG_W - 1);
  localparam logic [11:0] K_LAST        = 12'(IMG_H - 1);
  localparam bit          HAS_PAD       = (PAD_B != 0);
  // (PAD_B+3)%4 is PAD_B-1 when padding exists; unused otherwise.
  localparam logic [1:0]  PAD_LAST      = 2'((PAD_B + 3) % 4);
  localparam logic [5:0]  HDR_LAST      = 6'd53;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_FETCH,
    S_WAIT,
    S_PIXEL,
    S_PAD,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  hdr_idx_q, hdr_idx_d;
  logic [11:0] x_q, x_d;
  logic [11:0] k_q, k_d;
  logic [20:0] row_base_q, row_base_d;   // y*IMG_W of the row being streamed
  logic [1:0]  byte_q, byte_d;           // 0=B, 1=G, 2=R
  logic [1:0]  pad_q, pad_d;
  logic [15:0] pix_q, pix_d;

  // Header generation. Every 4-byte field starts at an index that is 2 mod 4,
  // so (idx+2)>>2 selects the field and (idx+2)%4 the little-endian byte.
  // The "BM" magic is treated as the top half of field 0, and planes/bpp
  // (two 2-byte fields) share field 7.
  logic [3:0]  hdr_field;
  logic [1:0]  hdr_sel;
  logic [31:0] hdr_word;
  logic [7:0]  hdr_byte;
  logic [5:0]  hdr_idx_p2;

  always_comb begin
    hdr_idx_p2 = hdr_idx_q + 6'd2;
    hdr_field  = hdr_idx_p2[5:2];
    hdr_sel    = hdr_idx_p2[1:0];
    case (hdr_field)
      4'd0:    hdr_word = 32'h4D42_0000;
      4'd1:    hdr_word = FILE_SZ_W;
      4'd3:    hdr_word = 32'd54;
      4'd4:    hdr_word = 32'd40;
      4'd5:    hdr_word = IMG_W_W;
      4'd6:    hdr_word = IMG_H_W;
      4'd7:    hdr_word = 32'h0018_0001;
      4'd9:    hdr_word = IMG_SZ_W;
      4'd10:   hdr_word = 32'd2835;
      4'd11:   hdr_word = 32'd2835;
      default: hdr_word = 32'd0;
    endcase
    hdr_byte = hdr_word[{hdr_sel, 3'b000} +: 8];
  end

  // RGB565 -> BGR888 by MSB replication, in emission order.
  logic [7:0] pix_byte;

  always_comb begin
    case (byte_q)
      2'd0:    pix_byte = {pix_q[4:0],   pix_q[4:2]};
      2'd1:    pix_byte = {pix_q[10:5],  pix_q[10:9]};
      default: pix_byte = {pix_q[15:11], pix_q[15:13]};
    endcase
  end

  assign bus.fb_addr = row_base_q + {9'd0, x_q};

  logic row_end;
  logic last_row;

  always_comb begin
    state_d    = state_q;
    hdr_idx_d  = hdr_idx_q;
    x_d        = x_q;
    k_d        = k_q;
    row_base_d = row_base_q;
    byte_d     = byte_q;
    pad_d      = pad_q;
    pix_d      = pix_q;
    row_end    = 1'b0;
    last_row   = (k_q == K_LAST);

    bus.fb_rd     = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = 8'h00;
    bus.out_last  = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d   = S_HEADER;
          hdr_idx_d = 6'd0;
        end
      end

      S_HEADER: begin
        bus.out_valid = 1'b1;
        bus.out_data  = hdr_byte;
        if (bus.out_ready) begin
          if (hdr_idx_q == HDR_LAST) begin
            state_d    = S_FETCH;
            x_d        = 12'd0;
            k_d        = 12'd0;
            row_base_d = LAST_ROW_BASE;
          end else begin
            hdr_idx_d = hdr_idx_q + 6'd1;
          end
        end
      end

      S_FETCH: begin
        bus.fb_rd = 1'b1;
        state_d   = S_WAIT;
      end

      S_WAIT: begin
        pix_d   = bus.fb_rdata;
        byte_d  = 2'd0;
        state_d = S_PIXEL;
      end

      S_PIXEL: begin
        bus.out_valid = 1'b1;
        bus.out_data  = pix_byte;
        // Without padding the R byte of the last pixel closes the file.
        bus.out_last  = !HAS_PAD && (byte_q == 2'd2) && (x_q == X_LAST) && last_row;
        if (bus.out_ready) begin
          if (byte_q == 2'd2) begin
            if (x_q != X_LAST) begin
              x_d     = x_q + 12'd1;
              state_d = S_FETCH;
            end else if (HAS_PAD) begin
              pad_d   = 2'd0;
              state_d = S_PAD;
            end else begin
              row_end = 1'b1;
            end
          end else begin
            byte_d = byte_q + 2'd1;
          end
        end
      end

      S_PAD: begin
        bus.out_valid = 1'b1;
        bus.out_data  = 8'h00;
        bus.out_last  = (pad_q == PAD_LAST) && last_row;
        if (bus.out_ready) begin
          if (pad_q == PAD_LAST) begin
            row_end = 1'b1;
          end else begin
            pad_d = pad_q + 2'd1;
          end
        end
      end

      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) begin
          state_d   = S_HEADER;
          hdr_idx_d = 6'd0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Rows are streamed bottom-up, so the row base walks down by IMG_W.
    if (row_end) begin
      if (!last_row) begin
        k_d        = k_q + 12'd1;
        x_d        = 12'd0;
        row_base_d = row_base_q - ROW_STEP;
        state_d    = S_FETCH;
      end else begin
        state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      hdr_idx_q  <= 6'd0;
      x_q        <= 12'd0;
      k_q        <= 12'd0;
      row_base_q <= 21'd0;
      byte_q     <= 2'd0;
      pad_q      <= 2'd0;
      pix_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      hdr_idx_q  <= hdr_idx_d;
      x_q        <= x_d;
      k_q        <= k_d;
      row_base_q <= row_base_d;
      byte_q     <= byte_d;
      pad_q      <= pad_d;
      pix_q      <= pix_d;
    end
  end

endmodule

// File: tb/tb_bmp_writer.sv
// Purpose : self-checking bench for bmp_writer (3x2 with padding, 4x2 without).
// Latency : reference stream built up front per file; DUT compared every cycle.
// Backpressure: out_ready randomised per file at a given duty.
module tb_bmp_writer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic st = 1'b0;
  logic rdy = 1'b0;
  int   sel = 0;

  logic start3, start4, busy3, done3, busy4, done4;

  bmp_writer_if b3();
  bmp_writer_if b4();

  bmp_writer #(.IMG_W(3), .IMG_H(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3), .bus(b3));
  bmp_writer #(.IMG_W(4), .IMG_H(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy4), .done(done4), .bus(b4));

  always #5 clk = ~clk;

  assign start3 = st && (sel == 0);
  assign start4 = st && (sel == 1);
  assign b3.out_ready = rdy;
  assign b4.out_ready = rdy;

  logic [15:0] mem3 [8];
  logic [15:0] mem4 [8];

  // Framebuffers with fixed one-cycle read latency.
  always @(posedge clk) if (b3.fb_rd) b3.fb_rdata <= mem3[b3.fb_addr[2:0]];
  always @(posedge clk) if (b4.fb_rd) b4.fb_rdata <= mem4[b4.fb_addr[2:0]];

  // View of the DUT under test.
  logic        m_valid, m_last, m_fb_rd, m_busy, m_done;
  logic [7:0]  m_data;
  logic [20:0] m_fb_addr;
  assign m_valid   = (sel == 1) ? b4.out_valid : b3.out_valid;
  assign m_last    = (sel == 1) ? b4.out_last  : b3.out_last;
  assign m_data    = (sel == 1) ? b4.out_data  : b3.out_data;
  assign m_fb_rd   = (sel == 1) ? b4.fb_rd     : b3.fb_rd;
  assign m_fb_addr = (sel == 1) ? b4.fb_addr   : b3.fb_addr;
  assign m_busy    = (sel == 1) ? busy4        : busy3;
  assign m_done    = (sel == 1) ? done4        : done3;

  int n_checks = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  int         exp_addr[$];
  logic [7:0] got[$];
  int         got_addr[$];
  logic [7:0] saved[$];
  int  bidx, fb_cnt;
  bit  mon_on = 1'b0, file_end, stall_p;
  logic [7:0] stall_d;
  logic       stall_l;

  task automatic check(input string name, input logic [31:0] g, input logic [31:0] w);
    n_checks++;
    if (g !== w) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, g, w);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  // ---------------- reference model ----------------
  function automatic int padded_row(input int w);
    return ((w * 3 + 3) / 4) * 4;
  endfunction

  function automatic logic [7:0] rep5(input logic [4:0] v);
    return {v, v[4:2]};
  endfunction

  function automatic logic [7:0] rep6(input logic [5:0] v);
    return {v, v[5:4]};
  endfunction

  task automatic push_le(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v[8*i +: 8]);
  endtask

  task automatic build_model(input int w, input int h);
    int isz;
    int a;
    logic [15:0] p;
    isz = padded_row(w) * h;
    exp_q.delete();
    exp_addr.delete();
    push_le(32'h4D42, 2);
    push_le(32'(54 + isz), 4);
    push_le(0, 4);
    push_le(54, 4);
    push_le(40, 4);
    push_le(32'(w), 4);
    push_le(32'(h), 4);
    push_le(1, 2);
    push_le(24, 2);
    push_le(0, 4);
    push_le(32'(isz), 4);
    push_le(2835, 4);
    push_le(2835, 4);
    push_le(0, 4);
    push_le(0, 4);
    for (int k = 0; k < h; k++) begin
      for (int x = 0; x < w; x++) begin
        a = (h - 1 - k) * w + x;
        exp_addr.push_back(a);
        p = (sel == 1) ? mem4[a] : mem3[a];
        exp_q.push_back(rep5(p[4:0]));
        exp_q.push_back(rep6(p[10:5]));
        exp_q.push_back(rep5(p[15:11]));
      end
      for (int j = 0; j < padded_row(w) - 3 * w; j++) exp_q.push_back(8'h00);
    end
  endtask

  // ---------------- one cycle: compare at negedge, return after posedge ----------------
  task automatic tick();
    @(negedge clk);
    if (mon_on) begin
      if (stall_p) begin
        check("stall_valid", 32'(m_valid), 1);
        check("stall_data", 32'(m_data), 32'(stall_d));
        check("stall_last", 32'(m_last), 32'(stall_l));
      end
      if (m_fb_rd) begin
        check("fb_rd_after_header", 32'(bidx >= 54), 1);
        if (fb_cnt < exp_addr.size())
          check($sformatf("fb_addr%0d", fb_cnt), 32'(m_fb_addr), 32'(exp_addr[fb_cnt]));
        else
          fail($sformatf("fb_rd_extra addr %0d", m_fb_addr));
        got_addr.push_back(int'(m_fb_addr));
        fb_cnt++;
      end
      if (m_valid && rdy) begin
        if (bidx < exp_q.size()) begin
          check($sformatf("byte%0d", bidx), 32'(m_data), 32'(exp_q[bidx]));
          check($sformatf("last%0d", bidx), 32'(m_last), 32'(bidx == exp_q.size() - 1));
        end else begin
          fail($sformatf("byte_extra %0h", m_data));
        end
        got.push_back(m_data);
        bidx++;
        if (bidx >= exp_q.size() || m_last) file_end = 1'b1;
      end
      stall_p = m_valid && !rdy;
      stall_d = m_data;
      stall_l = m_last;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    check({tag, "_valid"}, 32'(m_valid), 0);
    check({tag, "_last"}, 32'(m_last), 0);
    check({tag, "_data"}, 32'(m_data), 0);
    check({tag, "_fb_rd"}, 32'(m_fb_rd), 0);
    check({tag, "_fb_addr"}, 32'(m_fb_addr), 0);
    check({tag, "_busy"}, 32'(m_busy), 0);
    check({tag, "_done"}, 32'(m_done), 0);
  endtask

  // Streams one file from the selected DUT; optional stray start at byte 10
  // and optional reset when byte rst_at is about to be presented.
  task automatic run_file(input int s, input int duty, input bit spur,
                          input int rst_at, output bit aborted);
    int  cyc;
    bit  spur_done;
    aborted = 1'b0;
    sel = s;
    #1;
    build_model((s == 1) ? 4 : 3, 2);
    got.delete();
    got_addr.delete();
    bidx = 0;
    fb_cnt = 0;
    file_end = 1'b0;
    stall_p = 1'b0;
    spur_done = 1'b0;
    mon_on = 1'b1;
    rdy = ($urandom_range(0, 99) < duty);
    st = 1'b1;
    tick();
    st = 1'b0;
    check("start_busy", 32'(m_busy), 1);
    check("start_valid", 32'(m_valid), 1);
    check("start_data", 32'(m_data), 32'h42);
    check("start_done_clr", 32'(m_done), 0);
    cyc = 0;
    while (!file_end && cyc < 4000) begin
      rdy = ($urandom_range(0, 99) < duty);
      if (rst_at >= 0 && bidx == rst_at) begin
        rdy = 1'b0;
        mon_on = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_reset_state("midreset");
        aborted = 1'b1;
        return;
      end
      if (spur && !spur_done && bidx == 10) begin
        st = 1'b1;
        spur_done = 1'b1;
      end
      tick();
      st = 1'b0;
      cyc++;
    end
    mon_on = 1'b0;
    check("file_complete", 32'(file_end), 1);
    check("end_done", 32'(m_done), 1);
    check("end_busy", 32'(m_busy), 0);
    check("end_valid", 32'(m_valid), 0);
    check("byte_count", 32'(bidx), 32'(exp_q.size()));
    check("fb_rd_count", 32'(fb_cnt), 32'(exp_addr.size()));
  endtask

  logic [431:0] hdr_lit;
  int           addr_lit [6];
  logic [7:0]   pix_lit [9];
  bit           ab;

  initial begin
    hdr_lit = 432'h424D_4E00_0000_0000_0000_3600_0000_2800_0000_0300_0000_0200_0000_0100_1800_0000_0000_1800_0000_130B_0000_130B_0000_0000_0000_0000_0000;
    addr_lit = '{3, 4, 5, 0, 1, 2};
    pix_lit = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) begin
      mem3[i] = 16'(i);
      mem4[i] = 16'(i);
    end

    // Reset state of both instances.
    rst_n = 1'b0;
    repeat (3) tick();
    sel = 0; #1;
    chk_reset_state("rst3");
    sel = 1; #1;
    chk_reset_state("rst4");
    sel = 0;
    rst_n = 1'b1;
    tick();

    // 3x2, fb_rdata = address, continuous ready: header and row order.
    run_file(0, 100, 1'b0, -1, ab);
    check("hdr_size", 32'(got.size() >= 54), 1);
    for (int i = 0; i < 54 && i < got.size(); i++)
      check($sformatf("hdr_lit%0d", i), 32'(got[i]), 32'(hdr_lit[8*(53-i) +: 8]));
    check("addr_seq_len", 32'(got_addr.size()), 6);
    for (int i = 0; i < 6 && i < got_addr.size(); i++)
      check($sformatf("addr_lit%0d", i), 32'(got_addr[i]), 32'(addr_lit[i]));

    // Colour conversion with known pixels.
    mem3[3] = 16'hF800; mem3[4] = 16'h07E0; mem3[5] = 16'h001F; mem3[0] = 16'h8410;
    run_file(0, 100, 1'b0, -1, ab);
    if (got.size() >= 69) begin
      for (int i = 0; i < 9; i++)
        check($sformatf("pix_lit%0d", i), 32'(got[54+i]), 32'(pix_lit[i]));
      check("pad_lit", 32'({got[63], got[64], got[65]}), 0);
      check("gray_lit", 32'({got[66], got[67], got[68]}), 32'h848284);
    end else begin
      fail($sformatf("colour_file_short %0d", got.size()));
    end

    // Random pixels, 30% ready with a stray start, then same frame at full rate.
    for (int i = 0; i < 8; i++) mem3[i] = 16'($urandom);
    run_file(0, 30, 1'b1, -1, ab);
    saved = got;
    run_file(0, 100, 1'b0, -1, ab);
    check("replay_len", 32'(got.size()), 32'(saved.size()));
    for (int i = 0; i < got.size() && i < saved.size(); i++)
      check($sformatf("replay%0d", i), 32'(got[i]), 32'(saved[i]));

    // Reset mid-stream, then a clean file.
    for (int i = 0; i < 8; i++) mem3[i] = 16'($urandom);
    run_file(0, 60, 1'b0, 60, ab);
    check("reset_hit", 32'(ab), 1);
    run_file(0, 100, 1'b0, -1, ab);

    // 4x2: no padding, last flag on the final R byte.
    for (int i = 0; i < 8; i++) mem4[i] = 16'($urandom);
    mem4[3] = 16'hF800;
    run_file(1, 70, 1'b0, -1, ab);
    check("w4_size", 32'(got.size()), 78);
    if (got.size() == 78) begin
      check("w4_lastB", 32'(got[75]), 0);
      check("w4_lastR", 32'(got[77]), 32'hFF);
    end
    run_file(1, 100, 1'b0, -1, ab);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
